// File: rtl/decode_pkg.sv
// Shared types and defaults for the decode-stage register file.
// Pointer validity helper is used by both the array and the scoreboard.
package decode_pkg;

    localparam int REGS_PTR_W = 5;
    localparam int REGS_NUM   = 32;
    localparam int REG_SIZE   = 32;

    typedef logic [REGS_PTR_W-1:0] reg_ptr_t;
    typedef logic [REG_SIZE-1:0]   reg_data_t;

    // x0 and anything past the last register are never real targets
    function automatic logic ptr_ok(input int unsigned addr,
                                    input int unsigned num);
        return (addr != 0) && (addr < num);
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register busy tracking: reserve at issue, release at writeback.
// Also produces the per-read-port busy lookup with optional bypass.
module decode_scoreboard #(
    parameter int REGS_PTR_W = decode_pkg::REGS_PTR_W,
    parameter int REGS_NUM   = decode_pkg::REGS_NUM,
    parameter int RD_PORTS   = 2,
    parameter int WR_PORTS   = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 rsv_vld,
    input  logic [REGS_PTR_W-1:0]                rsv_addr,
    input  logic [WR_PORTS-1:0]                  we,
    input  logic [WR_PORTS-1:0][REGS_PTR_W-1:0]  wa,
    input  logic [RD_PORTS-1:0][REGS_PTR_W-1:0]  ra,
    output logic [RD_PORTS-1:0]                  rbusy,
    output logic [REGS_NUM-1:0]                  busy_vec
);

    import decode_pkg::*;

    logic [REGS_NUM-1:0] busy;
    logic [REGS_NUM-1:0] busy_nxt;

    // Next busy state: a new reserve owns the register over a release
    always_comb begin
        busy_nxt = busy;
        busy_nxt[0] = 1'b0;
        for (int i = 1; i < REGS_NUM; i++) begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (we[p] && (wa[p] == REGS_PTR_W'(i)))
                    busy_nxt[i] = 1'b0;
            end
            if (rsv_vld && (rsv_addr == REGS_PTR_W'(i)))
                busy_nxt[i] = 1'b1;
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // Read-side busy lookup; a same-cycle forwarded write hides busy
    always_comb begin
        rbusy = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            if (ptr_ok(32'(ra[r]), REGS_NUM)) begin
                rbusy[r] = busy[ra[r]];
                if (BYPASS) begin
                    for (int p = 0; p < WR_PORTS; p++) begin
                        if (we[p] && (wa[p] == ra[r]))
                            rbusy[r] = 1'b0;
                    end
                end
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/decode_regfile_mp.sv
// Multi-port decode register file with write->read bypass option,
// busy scoreboard and a registered same-address write collision flag.
module decode_regfile_mp #(
    parameter int REGS_PTR_W = decode_pkg::REGS_PTR_W,
    parameter int REGS_NUM   = decode_pkg::REGS_NUM,
    parameter int REG_SIZE   = decode_pkg::REG_SIZE,
    parameter int RD_PORTS   = 2,
    parameter int WR_PORTS   = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [WR_PORTS-1:0]                  we,
    input  logic [WR_PORTS-1:0][REGS_PTR_W-1:0]  wa,
    input  logic [WR_PORTS-1:0][REG_SIZE-1:0]    wd,
    input  logic [RD_PORTS-1:0][REGS_PTR_W-1:0]  ra,
    output logic [RD_PORTS-1:0][REG_SIZE-1:0]    rd,
    output logic [RD_PORTS-1:0]                  rbusy,
    input  logic                                 rsv_vld,
    input  logic [REGS_PTR_W-1:0]                rsv_addr,
    output logic [REGS_NUM-1:0]                  busy_vec,
    output logic                                 wr_conflict
);

    import decode_pkg::*;

    logic [REG_SIZE-1:0] regs [REGS_NUM];
    logic                conflict_now;

    // Array write; later ports overwrite earlier ones on the same target
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS_NUM; i++)
                regs[i] <= '0;
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (we[p] && ptr_ok(32'(wa[p]), REGS_NUM))
                    regs[wa[p]] <= wd[p];
            end
        end
    end

    // Detect two or more enabled ports hitting the same real register
    always_comb begin
        conflict_now = 1'b0;
        for (int p = 0; p < WR_PORTS; p++) begin
            for (int q = p + 1; q < WR_PORTS; q++) begin
                if (we[p] && we[q] && (wa[p] == wa[q]) &&
                    ptr_ok(32'(wa[p]), REGS_NUM))
                    conflict_now = 1'b1;
            end
        end
    end

    // Collision flag is a one-cycle registered pulse
    always_ff @(posedge clk) begin
        if (!rst_n)
            wr_conflict <= 1'b0;
        else
            wr_conflict <= conflict_now;
    end

    // Read muxes; highest matching write port forwards when bypass is on
    always_comb begin
        rd = '0;
        for (int r = 0; r < RD_PORTS; r++) begin
            if (ptr_ok(32'(ra[r]), REGS_NUM)) begin
                rd[r] = regs[ra[r]];
                if (BYPASS) begin
                    for (int p = 0; p < WR_PORTS; p++) begin
                        if (we[p] && (wa[p] == ra[r]))
                            rd[r] = wd[p];
                    end
                end
            end
        end
    end

    decode_scoreboard #(
        .REGS_PTR_W (REGS_PTR_W),
        .REGS_NUM   (REGS_NUM),
        .RD_PORTS   (RD_PORTS),
        .WR_PORTS   (WR_PORTS),
        .BYPASS     (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_vld  (rsv_vld),
        .rsv_addr (rsv_addr),
        .we       (we),
        .wa       (wa),
        .ra       (ra),
        .rbusy    (rbusy),
        .busy_vec (busy_vec)
    );

endmodule
